// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: immediate format select and base opcodes.
package rv32i_pkg;

  // Immediate format select, shared with the decoder's control encoding.
  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_fmt_e;

  // Major opcodes used when building test words.
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

endpackage

// File: rtl/imm_encoder_if.sv
// Input and output valid/ready streams of the immediate encoder.
interface imm_encoder_if;
  import rv32i_pkg::*;

  logic        in_valid;
  logic        in_ready;
  imm_fmt_e    in_fmt;
  logic [31:0] in_imm;
  logic [31:0] in_base;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_err;

  // Producer of words to encode and consumer of encoded words.
  modport master (
    output in_valid, in_fmt, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_insn, out_err
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_fmt, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_insn, out_err
  );
endinterface

// File: rtl/imm_fits.sv
// Range check: can the immediate be represented exactly in the given format.
module imm_fits
  import rv32i_pkg::*;
(
  input  imm_fmt_e    fmt,
  input  logic [31:0] imm,
  output logic        fits
);

  // Upper bits must be a pure sign extension; B/J offsets must be even.
  always_comb begin
    fits = 1'b0;
    unique case (fmt)
      IMM_I, IMM_S: fits = (&imm[31:11]) | ~(|imm[31:11]);
      IMM_B:        fits = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      IMM_J:        fits = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      default:      fits = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RV32I immediate encoder: S1 holds the input plus range check,
// S2 holds the packed word. Counts emitted words and emitted errors.
module imm_encoder
  import rv32i_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  imm_encoder_if.slave       bus,
  output logic [COUNT_W-1:0] enc_count,
  output logic [COUNT_W-1:0] err_count
);

  // Only imm[20:0] feeds the packing; the upper bits matter solely for the
  // range check, which is resolved before S1.
  logic        s1_valid_q, s1_valid_d;
  imm_fmt_e    s1_fmt_q,   s1_fmt_d;
  logic [20:0] s1_imm_q,   s1_imm_d;
  logic [31:0] s1_base_q,  s1_base_d;
  logic        s1_fits_q,  s1_fits_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_insn_q,  s2_insn_d;
  logic        s2_err_q,   s2_err_d;

  logic [COUNT_W-1:0] enc_q, enc_d;
  logic [COUNT_W-1:0] err_q, err_d;

  logic in_fits;
  logic in_hs, out_hs, s1_load, s2_load;

  imm_fits u_fits (
    .fmt  (bus.in_fmt),
    .imm  (bus.in_imm),
    .fits (in_fits)
  );

  // Place immediate bits into their format-specific positions over the base.
  function automatic logic [31:0] pack_imm(imm_fmt_e fmt, logic [20:0] imm,
                                           logic [31:0] base);
    logic [31:0] w;
    w = base;
    unique case (fmt)
      IMM_I: w[31:20] = imm[11:0];
      IMM_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      IMM_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      IMM_J: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      default: w = base;
    endcase
    return w;
  endfunction

  // Ready does not look at in_valid; reset masks both handshakes.
  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign bus.in_ready = !rst && (!s1_valid_q || !s2_valid_q || bus.out_ready);
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign out_hs       = !rst && s2_valid_q && bus.out_ready;

  assign bus.out_valid = s2_valid_q;
  assign bus.out_insn  = s2_insn_q;
  assign bus.out_err   = s2_err_q;
  assign enc_count     = enc_q;
  assign err_count     = err_q;

  // Next-state for both stages and the counters.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fmt_d   = s1_fmt_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    s1_fits_d  = s1_fits_q;
    s2_valid_d = s2_valid_q;
    s2_insn_d  = s2_insn_q;
    s2_err_d   = s2_err_q;
    enc_d      = enc_q;
    err_d      = err_q;

    // Data only moves with a real word, so a bubble leaves the old word in place.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_insn_d = pack_imm(s1_fmt_q, s1_imm_q, s1_base_q);
        s2_err_d  = !s1_fits_q;
      end
    end

    if (s1_load) begin
      s1_valid_d = in_hs;
      if (in_hs) begin
        s1_fmt_d  = bus.in_fmt;
        s1_imm_d  = bus.in_imm[20:0];
        s1_base_d = bus.in_base;
        s1_fits_d = in_fits;
      end
    end

    if (out_hs) begin
      enc_d = enc_q + COUNT_W'(1);
      if (s2_err_q) err_d = err_q + COUNT_W'(1);
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= IMM_I;
      s1_imm_q   <= '0;
      s1_base_q  <= '0;
      s1_fits_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_insn_q  <= '0;
      s2_err_q   <= 1'b0;
      enc_q      <= '0;
      err_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fmt_q   <= s1_fmt_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s1_fits_q  <= s1_fits_d;
      s2_valid_q <= s2_valid_d;
      s2_insn_q  <= s2_insn_d;
      s2_err_q   <= s2_err_d;
      enc_q      <= enc_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: a decode/mask model plus directed cases.
module tb_imm_encoder;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] enc_count, err_count;

  imm_encoder_if bus ();

  imm_encoder #(.COUNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          fmt;
    logic [31:0] imm;
    logic [31:0] base;
    int          cyc;
    bit          lit_insn_on;
    logic [31:0] lit_insn;
    bit          lit_err_on;
    logic        lit_err;
  } word_t;

  word_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int enc_m = 0;
  int err_m = 0;
  bit stall_p = 0;
  logic [31:0] held_insn;
  logic held_err;

  bit          lit_insn_on = 0;
  logic [31:0] lit_insn = '0;
  bit          lit_err_on = 0;
  logic        lit_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Standard RV32I immediate decoder (sign extension of the word's fields).
  function automatic logic [31:0] decode(input int fmt, input logic [31:0] w);
    case (fmt)
      0: return {{20{w[31]}}, w[31:20]};
      1: return {{20{w[31]}}, w[31:25], w[11:7]};
      2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // Bits of the word that carry the immediate.
  function automatic logic [31:0] imm_mask(input int fmt);
    case (fmt)
      0: return 32'hFFF0_0000;
      1, 2: return 32'hFE00_0F80;
      default: return 32'hFFFF_F000;
    endcase
  endfunction

  // What the format can hold: low bits sign-extended, B/J forced even.
  function automatic logic [31:0] trunc(input int fmt, input logic [31:0] v);
    case (fmt)
      0, 1: return {{20{v[11]}}, v[11:0]};
      2: return {{19{v[12]}}, v[12:1], 1'b0};
      default: return {{11{v[20]}}, v[20:1], 1'b0};
    endcase
  endfunction

  // Compare process: handshake tracking, stall stability, counters, words.
  always @(negedge clk) begin
    word_t w;
    logic [31:0] exp_imm;
    logic exp_err;
    cyc++;
    if (rst) begin
      chk("in_ready_rst", 32'(bus.in_ready), 32'd0);
      q.delete();
      enc_m = 0;
      err_m = 0;
      stall_p = 0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
      chk("out_valid", 32'(bus.out_valid), 32'((q.size() > 0) && (cyc - q[0].cyc >= 2)));
      chk("enc_count", 32'(enc_count), 32'(enc_m % 65536));
      chk("err_count", 32'(err_count), 32'(err_m % 65536));
      if (stall_p) begin
        chk("hold_insn", bus.out_insn, held_insn);
        chk("hold_err", 32'(bus.out_err), 32'(held_err));
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        w = q.pop_front();
        exp_imm = trunc(w.fmt, w.imm);
        exp_err = (exp_imm != w.imm);
        chk("err_flag", 32'(bus.out_err), 32'(exp_err));
        chk("round_trip", decode(w.fmt, bus.out_insn), exp_imm);
        chk("base_bits", bus.out_insn & ~imm_mask(w.fmt), w.base & ~imm_mask(w.fmt));
        if (w.lit_insn_on) chk("lit_insn", bus.out_insn, w.lit_insn);
        if (w.lit_err_on) chk("lit_err", 32'(bus.out_err), 32'(w.lit_err));
        enc_m++;
        if (exp_err) err_m++;
      end
      stall_p   = bus.out_valid && !bus.out_ready;
      held_insn = bus.out_insn;
      held_err  = bus.out_err;
      if (bus.in_valid && bus.in_ready) begin
        w.fmt = int'(bus.in_fmt);
        w.imm = bus.in_imm;
        w.base = bus.in_base;
        w.cyc = cyc;
        w.lit_insn_on = lit_insn_on;
        w.lit_insn = lit_insn;
        w.lit_err_on = lit_err_on;
        w.lit_err = lit_err;
        q.push_back(w);
        acc_cnt++;
      end
    end
  end

  // Offer one word and hold it until accepted; called at posedge+#1.
  task automatic send(input int f, input logic [31:0] imm, input logic [31:0] base,
                      input bit ci, input logic [31:0] ei, input bit ce, input logic ee);
    bit ok = 0;
    lit_insn_on = ci; lit_insn = ei; lit_err_on = ce; lit_err = ee;
    bus.in_valid = 1'b1;
    bus.in_fmt = imm_fmt_e'(f[1:0]);
    bus.in_imm = imm;
    bus.in_base = base;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    lit_insn_on = 0;
    lit_err_on = 0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return {{20{r[11]}}, r[11:0]};
      2: return {{19{r[12]}}, r[12:1], ($urandom_range(0, 7) == 0)};
      default: return {{11{r[20]}}, r[20:1], ($urandom_range(0, 7) == 0)};
    endcase
  endfunction

  initial begin
    int target;
    bus.in_valid = 1'b0;
    bus.in_fmt = IMM_I;
    bus.in_imm = '0;
    bus.in_base = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_insn", bus.out_insn, 32'h0);
    chk("rst_err", 32'(bus.out_err), 32'd0);
    chk("rst_enc", 32'(enc_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // I format with latency pin.
    send(0, 32'hFFFF_FFFF, 32'h0000_8093, 1, 32'hFFF0_8093, 1, 1'b0);
    @(negedge clk);
    chk("lat_s1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_s2", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();
    chk("enc_one", 32'(enc_count), 32'd1);

    send(1, 32'hFFFF_FFFC, 32'h0020_A023, 1, 32'hFE20_AE23, 1, 1'b0);
    send(2, 32'h0000_0008, 32'h0020_8063, 1, 32'h0020_8463, 1, 1'b0);
    send(3, 32'h0000_0800, 32'h0000_00EF, 1, 32'h0010_00EF, 1, 1'b0);
    drain();

    // Range errors.
    send(0, 32'h0000_0800, 32'h0000_8093, 1, 32'h8000_8093, 1, 1'b1);
    drain();
    chk("err_one", 32'(err_count), 32'd1);
    send(2, 32'h0000_0003, 32'h0020_8063, 0, '0, 1, 1'b1);
    send(3, 32'h0010_0000, 32'h0000_00EF, 0, '0, 1, 1'b1);
    drain();
    chk("err_three", 32'(err_count), 32'd3);

    // Backpressure: 5 words against a stalled output.
    do_reset();
    acc_cnt = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(i % 4, 32'(i * 2), 32'h1000_0000 * i + 32'h13, 0, '0, 0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_accepted", 32'(acc_cnt), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_enc", 32'(enc_count), 32'd5);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_fmt = IMM_S;
    bus.in_imm = 32'h0000_0123;
    bus.in_base = 32'h0000_0023;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_full", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_ov", 32'(bus.out_valid), 32'd0);
    chk("mid_enc", 32'(enc_count), 32'd0);
    chk("mid_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready_after", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Random round trip.
    target = acc_cnt + 10000;
    for (int c = 0; c < 60000 && acc_cnt < target; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_fmt = imm_fmt_e'($urandom_range(0, 3));
      bus.in_imm = rnd_imm();
      bus.in_base = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("rand_budget", 32'(acc_cnt >= target), 32'd1);
    drain();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined RV32I immediate encoder: the inverse of the immediate sign-extension decoder. It takes a signed 32-bit immediate, a format select and a base instruction word, and places the immediate bits into the I/S/B/J bit positions. It flags immediates that the format cannot represent and counts encoded and failed words. It sits in the boot/test instruction generator, feeding assembled words to the instruction memory writer over a valid/ready stream.

## Interface

- `COUNT_W`, default 16: width of the statistics counters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block can accept an input this cycle.
- `in_fmt` in 2: format select. 00 = I, 01 = S, 10 = B, 11 = J.
- `in_imm` in 32: sign-extended immediate value (byte offset for B/J).
- `in_base` in 32: instruction word with opcode/rd/rs/funct fields set. Bits at immediate positions are ignored.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts the output word.
- `out_insn` out 32: encoded instruction.
- `out_err` out 1: immediate not representable; qualified by `out_valid`.
- `enc_count` out COUNT_W: number of output handshakes.
- `err_count` out COUNT_W: number of output handshakes with `out_err` = 1.

## Operation

- Input handshake: `in_valid && in_ready` at a rising edge.
- Output handshake: `out_valid && out_ready` at a rising edge.
- Range check (representable iff all of):
  - I, S: `in_imm[31:11]` all equal.
  - B: `in_imm[31:12]` all equal, and `in_imm[0]` = 0.
  - J: `in_imm[31:20]` all equal, and `in_imm[0]` = 0.
- Packing. Base bits not listed below pass through unchanged.
  - I: `[31:20]` = `imm[11:0]`.
  - S: `[31:25]` = `imm[11:5]`; `[11:7]` = `imm[4:0]`.
  - B: `[31]` = `imm[12]`; `[30:25]` = `imm[10:5]`; `[11:8]` = `imm[4:1]`; `[7]` = `imm[11]`.
  - J: `[31]` = `imm[20]`; `[30:21]` = `imm[10:1]`; `[20]` = `imm[11]`; `[19:12]` = `imm[19:12]`.
- On a range error the word is still emitted, with the immediate truncated per the packing rules, and `out_err` = 1. The word is never dropped.
- Round-trip invariant: when `out_err` = 0, sign-extending `out_insn` with the same format returns `in_imm`.
- Counters: `enc_count` and `err_count` increment on each output handshake (`err_count` only when `out_err` = 1). Both wrap modulo 2^COUNT_W.

## Timing

- Two register stages:
  - S1 registers the inputs and the range-check result.
  - S2 is the output register holding the packed word.
- Latency: input accepted at edge N → `out_valid` = 1 after edge N+1, at the earliest.
- Throughput: 1 word/cycle while `out_ready` = 1.
- Stage advance rules:
  - S2 loads when it is empty or its output handshake occurs.
  - S1 loads when it is empty or it advances into S2.
- `in_ready` = !s1_valid || !s2_valid || out_ready. This is combinational, with no dependency on `in_valid`.
- Backpressure: with `out_ready` held 0, the block accepts exactly 2 words, then holds `in_ready` = 0. No loss, no duplication, order preserved.
- `out_insn` and `out_err` hold stable while `out_valid && !out_ready`.
- Simultaneous output handshake and input acceptance with both stages full: all stages shift in one cycle, no bubble.
- Reset values:
  - `out_valid` = 0, `out_insn` = 0, `out_err` = 0, both counters = 0, both stage valids = 0.
  - `in_ready` = 0 while `rst` is high, 1 in the first cycle after.
- Reset mid-operation: all in-flight words are discarded and counters are cleared. No handshake is recognised in a cycle where `rst` = 1.

## Structure

- Shared package `rv32i_pkg` holds:
  - enum `imm_fmt_e` (IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11), shared with the decoder's control encoding;
  - opcode constants used by the test plan.
- One combinational sub-module, `imm_fits`, computing (`fmt`, `imm`) → fits. The pipeline, packing and counters stay in `imm_encoder`.

## Test plan

- I: base 0x00008093, imm 0xFFFFFFFF, `out_ready` = 1 → `out_insn` 0xFFF08093, `out_err` 0, `out_valid` 2 edges after acceptance, `enc_count` = 1.
- S: base 0x0020A023, imm 0xFFFFFFFC → 0xFE20AE23. B: base 0x00208063, imm 0x00000008 → 0x00208463. J: base 0x000000EF, imm 0x00000800 → 0x001000EF. All with `out_err` 0.
- Errors:
  - I, imm 0x00000800 → `out_insn` 0x80008093, `out_err` 1, `err_count` 1.
  - B, imm 0x00000003 → `out_err` 1.
  - J, imm 0x00100000 → `out_err` 1.
- Backpressure: stream 5 words while `out_ready` is 0 for 4 cycles → exactly 2 accepted, then `in_ready` 0, output held stable. After release, all 5 words emerge in order, `enc_count` = 5.
- Random round trip: 10k random (fmt, imm, base) with random `out_ready` → decoder sign-extension of `out_insn` equals `in_imm` whenever `out_err` = 0. Non-immediate base bits are unchanged.
- Reset with both stages full and `out_valid` = 1 → next cycle `out_valid` 0, counters 0, `in_ready` 0 during reset, then 1. No stale word appears afterward.
